// File: rtl/crdma_mch_if.sv
// Bus bundle for crdma_mch: command, address issue, per-channel read return
// and merged output stream, plus status flags.
interface crdma_mch_if #(
  parameter int AW  = 14,
  parameter int DW  = 8,
  parameter int DN  = 7,
  parameter int NCH = 4,
  parameter int CHW = 2
) ();
  localparam int BW  = DN * DW;
  localparam int CMW = 2 * AW + 21 + CHW;

  logic [CMW-1:0]    cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW-1:0]     addr;
  logic              addr_first;
  logic              addr_last;
  logic [NCH-1:0]    addr_valid;
  logic [NCH-1:0]    addr_ready;
  logic [NCH*BW-1:0] rd_data;
  logic [NCH-1:0]    rd_valid;
  logic [NCH-1:0]    rd_ready;
  logic [BW-1:0]     s_data;
  logic              s_first;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_data, cmd_valid, addr_ready, rd_data, rd_valid, s_ready,
    output cmd_ready, addr, addr_first, addr_last, addr_valid, rd_ready,
           s_data, s_first, s_last, s_valid, busy, done
  );

  modport master (
    output cmd_data, cmd_valid, addr_ready, rd_data, rd_valid, s_ready,
    input  cmd_ready, addr, addr_first, addr_last, addr_valid, rd_ready,
           s_data, s_first, s_last, s_valid, busy, done
  );
endinterface

// File: rtl/crdma_mch.sv
// 2-D strided read address generator over NCH channels with an in-order
// tag FIFO that merges channel returns into one stream.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready=1
//   RUN   | issuing addresses of the latched command
module crdma_mch #(
  parameter int AW  = 14,
  parameter int DW  = 8,
  parameter int DN  = 7,
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int TD  = 8,
  parameter int TDW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  crdma_mch_if.slave bus
);
  localparam int BW  = DN * DW;
  localparam int CMW = 2 * AW + 21 + CHW;
  localparam int TGW = CHW + 3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            fin_r;
  logic [CHW-1:0]  ch_r;
  logic [AW-1:0]   d1_step_r;
  logic [7:0]      d1_size_r;
  logic [3:0]      d0_step_r;
  logic [7:0]      d0_size_r;
  logic [7:0]      i_r;
  logic [7:0]      j_r;
  logic [AW-1:0]   row_r;
  logic [AW-1:0]   addr_r;
  logic            done_r;

  logic [TGW-1:0]  tag_mem [TD];
  logic [TDW-1:0]  wr_ptr;
  logic [TDW-1:0]  rd_ptr;
  logic [TDW:0]    count;

  logic            full;
  logic            empty;
  logic            i_end;
  logic            at_first;
  logic            at_last;
  logic            push;
  logic            pop;
  logic [TGW-1:0]  head;
  logic [CHW-1:0]  head_ch;
  logic [NCH-1:0]  addr_valid_c;
  logic [NCH-1:0]  rd_ready_c;
  logic            s_valid_c;
  logic [BW-1:0]   s_data_c;
  logic [AW-1:0]   next_row;

  assign full     = (count == (TDW+1)'(TD));
  assign empty    = (count == '0);
  assign i_end    = (i_r == d0_size_r);
  assign at_first = (i_r == 8'd0) && (j_r == 8'd0);
  assign at_last  = i_end && (j_r == d1_size_r);
  assign next_row = row_r + d1_step_r;
  assign head     = tag_mem[rd_ptr];
  assign head_ch  = head[TGW-1:3];

  // A full FIFO refuses the push even when a pop lands in the same cycle.
  assign push = (state == RUN) && !full && bus.addr_ready[ch_r];
  assign pop  = s_valid_c && bus.s_ready;

  always_comb begin
    addr_valid_c = '0;
    rd_ready_c   = '0;
    s_valid_c    = 1'b0;
    s_data_c     = '0;
    for (int k = 0; k < NCH; k++) begin
      addr_valid_c[k] = (state == RUN) && !full && (ch_r == CHW'(k));
      if (head_ch == CHW'(k)) begin
        s_data_c      = bus.rd_data[k*BW +: BW];
        s_valid_c     = bus.rd_valid[k] && !empty;
        rd_ready_c[k] = bus.s_ready && !empty;
      end
    end
  end

  // Address walk is incremental: addr_r tracks row_r + i*d0_step.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      fin_r     <= 1'b0;
      ch_r      <= '0;
      d1_step_r <= '0;
      d1_size_r <= '0;
      d0_step_r <= '0;
      d0_size_r <= '0;
      i_r       <= '0;
      j_r       <= '0;
      row_r     <= '0;
      addr_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            fin_r     <= bus.cmd_data[CMW-1];
            ch_r      <= bus.cmd_data[2*AW+20 +: CHW];
            d1_step_r <= bus.cmd_data[AW+20 +: AW];
            d1_size_r <= bus.cmd_data[AW+12 +: 8];
            d0_step_r <= bus.cmd_data[AW+8 +: 4];
            d0_size_r <= bus.cmd_data[AW +: 8];
            row_r     <= bus.cmd_data[AW-1:0];
            addr_r    <= bus.cmd_data[AW-1:0];
            i_r       <= '0;
            j_r       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            if (at_last) begin
              state <= IDLE;
            end else if (i_end) begin
              i_r    <= '0;
              j_r    <= j_r + 8'd1;
              row_r  <= next_row;
              addr_r <= next_row;
            end else begin
              i_r    <= i_r + 8'd1;
              addr_r <= addr_r + AW'(d0_step_r);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done_r <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= {ch_r, at_first, at_last, fin_r && at_last};
        wr_ptr          <= wr_ptr + TDW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + TDW'(1);
      end
      if (push && !pop) begin
        count <= count + (TDW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (TDW+1)'(1);
      end
      done_r <= pop && head[0];
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.addr       = addr_r;
  assign bus.addr_first = at_first;
  assign bus.addr_last  = at_last;
  assign bus.addr_valid = addr_valid_c;
  assign bus.rd_ready   = rd_ready_c;
  assign bus.s_data     = s_data_c;
  assign bus.s_first    = head[2];
  assign bus.s_last     = head[1];
  assign bus.s_valid    = s_valid_c;
  assign bus.busy       = (state == RUN) || !empty;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_crdma_mch.sv
// Scoreboard bench for crdma_mch: commands push expected addresses and beats,
// a monitor pops and compares on every handshake; channel memories reply randomly.
module tb_crdma_mch;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int DN  = 7;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TD  = 8;
  localparam int TDW = 3;
  localparam int BW  = DN * DW;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [AW-1:0]  a;
    logic           first;
    logic           last;
  } aexp_t;

  typedef struct {
    logic [BW-1:0] d;
    logic          first;
    logic          last;
    logic          fin;
  } sexp_t;

  logic clk;
  logic rst_n;

  crdma_mch_if #(.AW(AW), .DW(DW), .DN(DN), .NCH(NCH), .CHW(CHW)) bus ();

  crdma_mch #(.AW(AW), .DW(DW), .DN(DN), .NCH(NCH), .CHW(CHW), .TD(TD), .TDW(TDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  aexp_t aq[$];
  sexp_t sq[$];
  logic [AW-1:0] pend [NCH][$];
  int hs_cnt = 0;
  int pop_cnt = 0;
  int sval_cnt = 0;
  int done_seen = 0;
  int done_exp_cnt = 0;
  logic done_due = 1'b0;
  int ar_rate = 100;
  int sr_rate = 100;
  int rv_rate [NCH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] memfn(input int k, input logic [AW-1:0] a);
    logic [3:0] kk;
    logic [7:0] kt;
    kk = 4'(k);
    kt = 8'(k * 37 + 1);
    return {kk, 2'b01, a, ~a, a ^ 14'h2A5, kt};
  endfunction

  // Channel memories, address/return/output monitors and done tracking.
  initial begin : env
    aexp_t ea;
    sexp_t es;
    bus.addr_ready = '0;
    bus.rd_valid   = '0;
    bus.rd_data    = '0;
    bus.s_ready    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        aq.delete();
        sq.delete();
        for (int k = 0; k < NCH; k++) pend[k].delete();
        done_due = 1'b0;
      end else begin
        if (bus.done || done_due) chk("done_pulse", 64'(bus.done), 64'(done_due));
        done_due = 1'b0;
        if (bus.done) done_seen++;
        if (bus.s_valid) sval_cnt++;
        for (int k = 0; k < NCH; k++) begin
          if (bus.addr_valid[k] && bus.addr_ready[k]) begin
            hs_cnt++;
            pend[k].push_back(bus.addr);
            chk("addr_expected", 64'(aq.size() > 0), 64'd1);
            if (aq.size() > 0) begin
              ea = aq.pop_front();
              chk("addr", 64'(bus.addr), 64'(ea.a));
              chk("addr_first", 64'(bus.addr_first), 64'(ea.first));
              chk("addr_last", 64'(bus.addr_last), 64'(ea.last));
              chk("addr_valid", 64'(bus.addr_valid), 64'(1 << ea.ch));
            end
          end
        end
        for (int k = 0; k < NCH; k++) begin
          if (bus.rd_valid[k] && bus.rd_ready[k]) begin
            chk("rd_pending", 64'(pend[k].size() > 0), 64'd1);
            if (pend[k].size() > 0) void'(pend[k].pop_front());
          end
        end
        if (bus.s_valid && bus.s_ready) begin
          pop_cnt++;
          chk("s_expected", 64'(sq.size() > 0), 64'd1);
          if (sq.size() > 0) begin
            es = sq.pop_front();
            chk("s_data", 64'(bus.s_data), 64'(es.d));
            chk("s_first", 64'(bus.s_first), 64'(es.first));
            chk("s_last", 64'(bus.s_last), 64'(es.last));
            if (es.fin) begin
              done_due = 1'b1;
              done_exp_cnt++;
            end
          end
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
        bus.addr_ready[k] = ($urandom_range(99) < ar_rate);
        if (pend[k].size() > 0 && $urandom_range(99) < rv_rate[k]) begin
          bus.rd_valid[k]        = 1'b1;
          bus.rd_data[k*BW +: BW] = memfn(k, pend[k][0]);
        end else if (pend[k].size() == 0) begin
          bus.rd_valid[k]        = ($urandom_range(99) < 20);
          bus.rd_data[k*BW +: BW] = BW'({$urandom, $urandom});
        end else begin
          bus.rd_valid[k] = 1'b0;
        end
      end
      bus.s_ready = ($urandom_range(99) < sr_rate);
    end
  end

  task automatic set_rates(input int ar, input int sr, input int rv);
    ar_rate = ar;
    sr_rate = sr;
    for (int k = 0; k < NCH; k++) rv_rate[k] = rv;
  endtask

  task automatic send_cmd(input logic fin, input logic [CHW-1:0] ch, input logic [AW-1:0] d1_step,
                          input logic [7:0] d1_size, input logic [3:0] d0_step,
                          input logic [7:0] d0_size, input logic [AW-1:0] base);
    bit ok;
    int t;
    aexp_t ea;
    sexp_t es;
    @(posedge clk);
    #1;
    bus.cmd_data  = {fin, ch, d1_step, d1_size, d0_step, d0_size, base};
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("cmd_accept", 64'(ok), 64'd1);
    if (ok) begin
      for (int j = 0; j <= int'(d1_size); j++) begin
        for (int i = 0; i <= int'(d0_size); i++) begin
          t        = int'(base) + j * int'(d1_step) + i * int'(d0_step);
          ea.ch    = ch;
          ea.a     = AW'(t);
          ea.first = (i == 0) && (j == 0);
          ea.last  = (i == int'(d0_size)) && (j == int'(d1_size));
          aq.push_back(ea);
          es.d     = memfn(int'(ch), ea.a);
          es.first = ea.first;
          es.last  = ea.last;
          es.fin   = fin && ea.last;
          sq.push_back(es);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!bus.busy && aq.size() == 0 && sq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  initial begin : main
    int h0;
    int p0;
    int d0;
    int s0;
    bit ok;
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    set_rates(100, 100, 100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_addr_valid", 64'(bus.addr_valid), 64'd0);
    chk("rst_s_valid", 64'(bus.s_valid), 64'd0);
    chk("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // 3x2 walk on channel 1, all readies high
    send_cmd(1'b0, 2'd1, 14'h20, 8'd1, 4'd1, 8'd2, 14'h10);
    drain();

    // address wrap at the top of the space
    set_rates(60, 60, 60);
    send_cmd(1'b0, 2'd3, 14'h0, 8'd0, 4'd1, 8'd3, 14'h3FFE);
    drain();

    // 1x1 with fin: single first+last beat and a done pulse
    set_rates(100, 100, 100);
    d0 = done_seen;
    send_cmd(1'b1, 2'd2, 14'h5, 8'd0, 4'd3, 8'd0, 14'h123);
    drain();
    repeat (2) @(negedge clk);
    chk("done_1x1", 64'(done_seen - d0), 64'd1);

    // ch2 data ready before ch0: ch0 must still drain first
    set_rates(100, 100, 100);
    rv_rate[0] = 0;
    send_cmd(1'b0, 2'd0, 14'h0, 8'd0, 4'd1, 8'd1, 14'h200);
    send_cmd(1'b0, 2'd2, 14'h0, 8'd0, 4'd2, 8'd1, 14'h300);
    repeat (12) @(negedge clk);
    chk("order_rd_valid2", 64'(bus.rd_valid[2]), 64'd1);
    chk("order_rd_ready2", 64'(bus.rd_ready[2]), 64'd0);
    chk("order_s_valid", 64'(bus.s_valid), 64'd0);
    chk("order_pending", 64'(sq.size()), 64'd4);
    rv_rate[0] = 100;
    drain();

    // tag FIFO fill with output stalled, then one pop frees one slot
    set_rates(100, 0, 100);
    h0 = hs_cnt;
    p0 = pop_cnt;
    send_cmd(1'b0, 2'($urandom_range(NCH-1)), 14'h40, 8'd2, 4'd2, 8'd3, 14'h1000);
    repeat (20) @(negedge clk);
    chk("fill_handshakes", 64'(hs_cnt - h0), 64'd8);
    chk("fill_addr_valid", 64'(bus.addr_valid), 64'd0);
    sr_rate = 100;
    @(negedge clk);
    sr_rate = 0;
    repeat (10) @(negedge clk);
    chk("fill_one_pop", 64'(pop_cnt - p0), 64'd1);
    chk("fill_one_push", 64'(hs_cnt - h0), 64'd9);
    sr_rate = 100;
    drain();

    // randomized traffic, back-to-back commands
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ar_rate = 30 + $urandom_range(70);
      sr_rate = 30 + $urandom_range(70);
      for (int k = 0; k < NCH; k++) rv_rate[k] = 30 + $urandom_range(70);
      send_cmd(1'($urandom_range(1)), 2'($urandom_range(NCH-1)), 14'($urandom),
               8'($urandom_range(3)), 4'($urandom), 8'($urandom_range(4)), 14'($urandom));
      if (c % 10 == 9) drain();
    end
    drain();

    // reset in the middle of a 6-address fin command
    set_rates(100, 0, 100);
    h0 = hs_cnt;
    d0 = done_seen;
    send_cmd(1'b1, 2'd3, 14'h100, 8'd1, 4'd4, 8'd2, 14'h0800);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (hs_cnt - h0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reset_progress", 64'(ok), 64'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_handshakes", 64'(hs_cnt - h0), 64'd3);
    chk("mid_reset_busy", 64'(bus.busy), 64'd0);
    chk("mid_reset_addr_valid", 64'(bus.addr_valid), 64'd0);
    chk("mid_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    sr_rate = 100;
    s0 = sval_cnt;
    repeat (30) @(negedge clk);
    chk("mid_reset_no_s_valid", 64'(sval_cnt - s0), 64'd0);
    chk("mid_reset_no_done", 64'(done_seen - d0), 64'd0);

    chk("done_total", 64'(done_seen), 64'(done_exp_cnt));
    chk("addr_queue_empty", 64'(aq.size()), 64'd0);
    chk("beat_queue_empty", 64'(sq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crdma_mch.md
CRDMA_MCH -- requirements
Module: crdma_mch

Interface
REQ-001 Parameter: AW, default 14, address width.
REQ-002 Parameter: DW, default 8, element width.
REQ-003 Parameter: DN, default 7, elements per beat; beat width BW=DN*DW.
REQ-004 Parameter: NCH, default 4, read channel count; CHW, default 2, channel-select width (NCH<=2^CHW).
REQ-005 Parameter: TD, default 8, tag FIFO depth, power of two; TDW, default 3, log2(TD).
REQ-006 Derived: CMW=2*AW+21+CHW, command width.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset; synchronous, active-high (1 = reset).
REQ-009 cmd_data  input  CMW  {fin, ch[CHW], d1_step[AW], d1_size[8], d0_step[4], d0_size[8], base[AW]}, MSB first; sizes encode count-1.
REQ-010 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-011 addr  output  AW  read address, shared by all channels.
REQ-012 addr_first / addr_last  output  1 / 1  first / last address of the current command.
REQ-013 addr_valid  output  NCH  one-hot valid toward the selected channel.
REQ-014 addr_ready  input  NCH  per-channel address ready.
REQ-015 rd_data  input  NCH*BW  channel k data at bits [k*BW +: BW].
REQ-016 rd_valid / rd_ready  input / output  NCH / NCH  per-channel return handshake.
REQ-017 s_data  output  BW  merged data stream.
REQ-018 s_first / s_last  output  1 / 1  beat carries the first / last address of its command.
REQ-019 s_valid / s_ready  output / input  1 / 1  output handshake.
REQ-020 busy  output  1  address generation active, or tag FIFO non-empty.
REQ-021 done  output  1  one-cycle pulse: final beat of a fin=1 command accepted.

Function
REQ-022 FSM states: IDLE and RUN; cmd_ready=1 only in IDLE.
REQ-023 cmd_valid&cmd_ready: latch all fields; clear i (dim0) and j (dim1) counters; row=base; go to RUN.
REQ-024 First addr_valid asserts the cycle after acceptance (latency 1).
REQ-025 Address generation: addr=row+i*d0_step, mod 2^AW (wraps, no error); row advances by d1_step, mod 2^AW, whenever i wraps; no multiplier.
REQ-026 Order: i runs 0..d0_size, then j increments; 256x256 addresses max.
REQ-027 In RUN: addr_valid[ch]=1 and other bits 0 when the tag FIFO is not full; all bits 0 when full.
REQ-028 Full tag FIFO blocks the push even if a pop occurs in the same cycle.
REQ-029 A pending address holds addr, addr_first, addr_last and addr_valid stable until addr_ready[ch].
REQ-030 addr_first=1 only on (i=0,j=0); addr_last=1 only on (i=d0_size,j=d1_size); both may be 1 together (1x1 command).
REQ-031 Each address handshake pushes tag {ch, first, last, fin&last}.
REQ-032 Handshake of the addr_last address: return to IDLE next cycle; a new command may then be accepted while earlier data still drains.
REQ-033 Return merge: head tag channel h; rd_ready[h]=s_ready & !empty; all other rd_ready bits 0.
REQ-034 Merge outputs: s_valid=rd_valid[h] & !empty; s_data=rd_data[h]; s_first/s_last from the head tag.
REQ-035 s_valid&s_ready pops the tag; output order equals address issue order across channels and commands.
REQ-036 done is registered: it asserts the cycle after a pop whose tag fin bit is 1.
REQ-037 Tag count ranges 0..TD; a simultaneous push and pop leaves the count unchanged.
REQ-038 An rd_valid beat on a non-head channel is not consumed and has no effect.

Reset
REQ-039 While rst_n=1 at a clock edge: state=IDLE; counters, row and FIFO pointers and count cleared; done=0.
REQ-040 Outputs after reset: addr_valid=0, s_valid=0, rd_ready=0, busy=0, cmd_ready=1.
REQ-041 Reset mid-command discards all tags and progress; no done pulse follows.

Verification
REQ-042 Command base=0x10, d0_size=2, d0_step=1, d1_size=1, d1_step=0x20, ch=1, all readies 1: addr sequence 0x10,0x11,0x12,0x30,0x31,0x32 on addr_valid=4'b0010; first on beat 0, last on beat 5.
REQ-043 base=0x3FFE, d0_size=3, d0_step=1: addresses 0x3FFE,0x3FFF,0x0000,0x0001.
REQ-044 Cmd A on ch0 (2 addr), then cmd B on ch2 (2 addr); ch2 returns data before ch0: s_data order A0,A1,B0,B1; rd_ready[2]=0 until A1 pops.
REQ-045 s_ready=0 with TD=8: addr_valid drops after 8 address handshakes; one pop re-enables exactly one push.
REQ-046 1x1 command with fin=1: addr_first=addr_last=1; done pulses one cycle after the beat is accepted.
REQ-047 Reset asserted after 3 of 6 addresses: next cycle busy=0, addr_valid=0, cmd_ready=1; no s_valid and no done afterwards.
